// File: rtl/fifo_pkg.sv
// Shared defaults and pointer helpers for the flexible synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_AE_LEVEL = 1;

  // Pointer width for a DEPTH-entry ring; at least one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Ring increment that wraps DEPTH-1 -> 0, so DEPTH need not be a power of two.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: clears on reset or clr, advances on inc.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Pointer register; reset and clr win over an increment in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clr) ptr <= '0;
    else if (inc)     ptr <= PTR_W'(wrap_inc(int'(ptr), DEPTH));
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// Synchronous show-ahead FIFO, any DEPTH >= 2, with occupancy count and
// almost-full/almost-empty flags. Define SYNC_FIFO_WATERMARK_EN to add the
// max_level peak-occupancy output.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
`ifdef SYNC_FIFO_WATERMARK_EN
  output logic [CNT_W-1:0]  max_level,
`endif
  output logic [CNT_W-1:0]  count,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic                         wr_en, rd_en;
  logic [CNT_W-1:0]             count_next;

  // Ready/valid come only from the registered count, so a full FIFO refuses
  // a write even while a read drains it in the same cycle (and vice versa).
  assign s_ready = (count != FULL_C);
  assign m_valid = (count != '0);
  assign wr_en   = s_valid & s_ready;
  assign rd_en   = m_valid & m_ready;

  assign m_data       = mem[rd_ptr];
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (wr_en),
    .ptr   (wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .clr   (flush),
    .inc   (rd_en),
    .ptr   (rd_ptr)
  );

  // Occupancy after this cycle's handshakes; a simultaneous write and read cancel.
  always_comb begin
    count_next = count;
    if (wr_en && !rd_en)      count_next = count + CNT_W'(1);
    else if (rd_en && !wr_en) count_next = count - CNT_W'(1);
  end

  // Storage write; contents are never cleared, only the pointers are.
  always_ff @(posedge clk) begin
    if (wr_en && !reset && !flush) mem[wr_ptr] <= s_data;
  end

  // Occupancy register; reset and flush discard everything.
  always_ff @(posedge clk) begin
    if (reset || flush) count <= '0;
    else                count <= count_next;
  end

`ifdef SYNC_FIFO_WATERMARK_EN
  // Peak occupancy since the last reset or flush.
  always_ff @(posedge clk) begin
    if (reset || flush)            max_level <= '0;
    else if (count_next > max_level) max_level <= count_next;
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex at DATA_W=8, DEPTH=5, AF=4, AE=1.
module tb_sync_fifo_flex;

  localparam int DW = 8;
  localparam int DP = 5;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          reset, flush, s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0] s_data, m_data;
  logic [CW-1:0] count;
  logic          almost_full, almost_empty;
`ifdef SYNC_FIFO_WATERMARK_EN
  logic [CW-1:0] max_level;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  sync_fifo_flex #(.DATA_W(DW), .DEPTH(DP), .AF_LEVEL(4), .AE_LEVEL(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
`ifdef SYNC_FIFO_WATERMARK_EN
    .max_level    (max_level),
`endif
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  // One vector: inputs for a cycle and the outputs expected just after its edge.
  typedef struct {
    string         name;
    logic          fl, sv;
    logic [DW-1:0] sd;
    logic          mr;
    logic          sr, mv;
    logic          dchk;
    logic [DW-1:0] md;
    logic [CW-1:0] cnt;
    logic          af, ae;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string nm, input logic fl, sv, input logic [DW-1:0] sd,
                              input logic mr, sr, mv, dchk, input logic [DW-1:0] md,
                              input logic [CW-1:0] cnt, input logic af, ae);
    vec_t v;
    v.name = nm; v.fl = fl; v.sv = sv; v.sd = sd; v.mr = mr;
    v.sr = sr; v.mv = mv; v.dchk = dchk; v.md = md; v.cnt = cnt; v.af = af; v.ae = ae;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic fl, sv, input logic [DW-1:0] sd, input logic mr);
    flush = fl; s_valid = sv; s_data = sd; m_ready = mr;
  endtask

  // Clock one edge with the given inputs, then sample outputs 1 time unit later.
  task automatic step(input logic fl, sv, input logic [DW-1:0] sd, input logic mr);
    drive(fl, sv, sd, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] hd;

    reset = 1'b1;
    idle();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_ae", 32'(almost_empty), 1);

    // Fill with m_ready low, overflow attempt, then drain in order.
    //            name     fl sv  sd     mr sr mv dc md     cnt af ae
    vt.push_back(mk("w11", 0, 1, 8'h11, 0, 1, 1, 1, 8'h11, 1, 0, 1));
    vt.push_back(mk("w12", 0, 1, 8'h12, 0, 1, 1, 1, 8'h11, 2, 0, 0));
    vt.push_back(mk("w13", 0, 1, 8'h13, 0, 1, 1, 1, 8'h11, 3, 0, 0));
    vt.push_back(mk("w14", 0, 1, 8'h14, 0, 1, 1, 1, 8'h11, 4, 1, 0));
    vt.push_back(mk("w15", 0, 1, 8'h15, 0, 0, 1, 1, 8'h11, 5, 1, 0));
    vt.push_back(mk("w16", 0, 1, 8'h16, 0, 0, 1, 1, 8'h11, 5, 1, 0));
    vt.push_back(mk("r1",  0, 0, 8'h00, 1, 1, 1, 1, 8'h12, 4, 1, 0));
    vt.push_back(mk("r2",  0, 0, 8'h00, 1, 1, 1, 1, 8'h13, 3, 0, 0));
    vt.push_back(mk("r3",  0, 0, 8'h00, 1, 1, 1, 1, 8'h14, 2, 0, 0));
    vt.push_back(mk("r4",  0, 0, 8'h00, 1, 1, 1, 1, 8'h15, 1, 0, 1));
    vt.push_back(mk("r5",  0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 1));
    vt.push_back(mk("r6e", 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 1));

    foreach (vt[i]) begin
      step(vt[i].fl, vt[i].sv, vt[i].sd, vt[i].mr);
      chk({vt[i].name, "_count"}, 32'(count), 32'(vt[i].cnt));
      chk({vt[i].name, "_s_ready"}, 32'(s_ready), 32'(vt[i].sr));
      chk({vt[i].name, "_m_valid"}, 32'(m_valid), 32'(vt[i].mv));
      chk({vt[i].name, "_af"}, 32'(almost_full), 32'(vt[i].af));
      chk({vt[i].name, "_ae"}, 32'(almost_empty), 32'(vt[i].ae));
      if (vt[i].dchk) chk({vt[i].name, "_m_data"}, 32'(m_data), 32'(vt[i].md));
    end

    // Streaming: preload 2, then 12 cycles of write+read; pointers wrap twice.
    step(0, 1, 8'hA1, 0);
    step(0, 1, 8'hA2, 0);
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'hA2);
    chk("pre_stream_count", 32'(count), 2);
    for (int i = 0; i < 12; i++) begin
      chk("stream_m_data", 32'(m_data), 32'(exp_q[0]));
      hd = exp_q.pop_front();
      exp_q.push_back(8'(8'h30 + i));
      step(0, 1, 8'(8'h30 + i), 1);
      chk("stream_count", 32'(count), 2);
    end
    // Remaining entries should be 0x3A, 0x3B.

    // Top up to full, then write+read while full: read wins, write refused.
    step(0, 1, 8'h40, 0);
    step(0, 1, 8'h41, 0);
    step(0, 1, 8'h42, 0);
    chk("full_count", 32'(count), 5);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_head", 32'(m_data), 32'h3A);
    step(0, 1, 8'h50, 1);
    chk("full_rw_count", 32'(count), 4);
    chk("full_rw_s_ready", 32'(s_ready), 1);
    step(0, 1, 8'h50, 0);
    chk("refill_count", 32'(count), 5);
    begin
      logic [DW-1:0] drain_exp[5];
      drain_exp = '{8'h3B, 8'h40, 8'h41, 8'h42, 8'h50};
      for (int i = 0; i < 5; i++) begin
        chk("drain_m_data", 32'(m_data), 32'(drain_exp[i]));
        step(0, 0, 8'h00, 1);
      end
    end
    chk("drain_m_valid", 32'(m_valid), 0);

    // Flush at count 3 overrides same-cycle write and read.
    step(0, 1, 8'h61, 0);
    step(0, 1, 8'h62, 0);
    step(0, 1, 8'h63, 0);
    chk("pre_flush_count", 32'(count), 3);
    step(1, 1, 8'h64, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_m_valid", 32'(m_valid), 0);
    chk("flush_s_ready", 32'(s_ready), 1);
    chk("flush_ae", 32'(almost_empty), 1);
    // Write into empty with m_ready high: read is blocked, entry shows next cycle.
    step(0, 1, 8'h71, 1);
    chk("post_flush_count", 32'(count), 1);
    chk("post_flush_m_data", 32'(m_data), 32'h71);

`ifdef SYNC_FIFO_WATERMARK_EN
    chk("wm_after_flush_write", 32'(max_level), 1);
`endif

    // Reset mid-stream at count 3.
    step(0, 1, 8'h72, 0);
    step(0, 1, 8'h73, 0);
    chk("pre_rst_count", 32'(count), 3);
    reset = 1'b1;
    step(0, 1, 8'h74, 1);
    reset = 1'b0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_m_valid", 32'(m_valid), 0);
    chk("mid_rst_s_ready", 32'(s_ready), 1);
    step(0, 1, 8'h81, 0);
    chk("post_rst_m_data", 32'(m_data), 32'h81);
    step(0, 0, 8'h00, 1);
    chk("post_rst_empty", 32'(m_valid), 0);

`ifdef SYNC_FIFO_WATERMARK_EN
    // Peak tracking: fill to 4, drain to 0, then flush.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'(i), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);
    chk("wm_count", 32'(count), 0);
    chk("wm_peak", 32'(max_level), 4);
    step(1, 0, 8'h00, 0);
    chk("wm_flush", 32'(max_level), 0);
`endif

    idle();
    if (hd === 8'hxx) n_fail += 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
